temporizador_preemptivo: RTL and testbench



---
 rtl/temporizador_preemptivo.sv | 203 ++++++++++++++++++++
 tb/tb_temporizador_preemptivo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporizador_preemptivo.sv
// Preemption timer: counts a per-context quantum and, on expiry or a forced request,
// pauses fetch while a programmable instruction stub is fed to the core.
module temporizador_preemptivo #(
  parameter int                DATA_W          = 32,
  parameter int                CTX_W           = 32,
  parameter int                QUANTUM_W       = 16,
  parameter int                DEFAULT_QUANTUM = 300,
  parameter int                NUM_CTX         = 4,
  parameter int                STUB_DEPTH      = 8,
  parameter logic [DATA_W-1:0] NOP_INSTR       = 32'hA000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CTX_W-1:0]     contexto,
  input  logic [DATA_W-1:0]    end_pc,
  input  logic                 enable,
  input  logic                 force_switch,
  input  logic                 fetch_ack,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [7:0]           cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  output logic [DATA_W-1:0]    saida_instrucao,
  output logic                 flag_pausa,
  output logic [DATA_W-1:0]    saved_pc,
  output logic [QUANTUM_W-1:0] quantum_left,
  output logic [15:0]          switch_count
);

  localparam int CTX_IDX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int SIDX_W    = (STUB_DEPTH > 1) ? $clog2(STUB_DEPTH) : 1;
  localparam int LEN_W     = SIDX_W + 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_PAUSE = 1'b1;

  localparam logic [CTX_W-1:0]  NUM_CTX_C    = CTX_W'(NUM_CTX);
  localparam logic [7:0]        NUM_CTX_A    = 8'(NUM_CTX);
  localparam logic [7:0]        STUB_DEPTH_A = 8'(STUB_DEPTH);
  localparam logic [DATA_W-1:0] STUB_DEPTH_D = DATA_W'(STUB_DEPTH);

  logic [0:0]           state_reg, state_next;
  logic [QUANTUM_W-1:0] counter_reg, counter_next;
  logic [SIDX_W-1:0]    idx_reg, idx_next;
  logic [LEN_W-1:0]     len_reg;
  logic [CTX_W-1:0]     ctx_prev_reg;
  logic [DATA_W-1:0]    saved_pc_reg, saved_pc_next;
  logic [15:0]          switch_count_reg, switch_count_next;

  logic [QUANTUM_W-1:0] quantum_reg [NUM_CTX];
  logic [DATA_W-1:0]    stub_reg    [STUB_DEPTH];

  logic [CTX_IDX_W-1:0] ctx_idx;
  logic [CTX_IDX_W-1:0] cfg_q_idx;
  logic [SIDX_W-1:0]    cfg_s_idx;
  logic [QUANTUM_W-1:0] q_cur;
  logic                 ctx_active;
  logic                 ctx_changed;
  logic                 counting;
  logic                 expiry;
  logic                 switch_now;
  logic                 stub_last;
  logic                 quantum_we;
  logic                 stub_we;
  logic                 len_we;
  logic [LEN_W-1:0]     len_clamped;
  logic [NUM_CTX-1:0]   quantum_hit;
  logic [STUB_DEPTH-1:0] stub_hit;

  // ---------------------------------------------------------------- decode
  assign ctx_idx     = CTX_IDX_W'(contexto % NUM_CTX_C);
  assign cfg_q_idx   = CTX_IDX_W'(cfg_addr % NUM_CTX_A);
  assign cfg_s_idx   = SIDX_W'(cfg_addr % STUB_DEPTH_A);
  assign q_cur       = quantum_reg[ctx_idx];
  assign ctx_active  = (contexto != '0);
  assign ctx_changed = (contexto != ctx_prev_reg);
  assign counting    = enable && ctx_active;

  // Extra bit on the compare so counter+1 never wraps below the quantum.
  assign expiry = counting && !ctx_changed && (q_cur != '0) &&
                  (({1'b0, counter_reg} + {{QUANTUM_W{1'b0}}, 1'b1}) >= {1'b0, q_cur});

  assign switch_now = (state_reg == ST_RUN) && (expiry || (force_switch && ctx_active));
  assign stub_last  = ({1'b0, idx_reg} == (len_reg - LEN_W'(1)));

  // Stub contents and length are frozen while a stub is being emitted.
  assign quantum_we = cfg_we && (cfg_sel == 2'd0);
  assign stub_we    = cfg_we && (cfg_sel == 2'd1) && (state_reg == ST_RUN);
  assign len_we     = cfg_we && (cfg_sel == 2'd2) && (state_reg == ST_RUN);

  always_comb begin
    len_clamped = LEN_W'(cfg_data);
    if (cfg_data == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_data > STUB_DEPTH_D) begin
      len_clamped = LEN_W'(STUB_DEPTH);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTX; gi++) begin : g_quantum_hit
      assign quantum_hit[gi] = quantum_we && (cfg_q_idx == CTX_IDX_W'(gi));
    end
    for (gi = 0; gi < STUB_DEPTH; gi++) begin : g_stub_hit
      assign stub_hit[gi] = stub_we && (cfg_s_idx == SIDX_W'(gi));
    end
  endgenerate

  // ------------------------------------------------------------ next state
  always_comb begin
    state_next        = state_reg;
    counter_next      = counter_reg;
    idx_next          = idx_reg;
    saved_pc_next     = saved_pc_reg;
    switch_count_next = switch_count_reg;
    case (state_reg)
      ST_RUN: begin
        if (switch_now) begin
          state_next    = ST_PAUSE;
          idx_next      = '0;
          counter_next  = '0;
          saved_pc_next = end_pc;
        end else if (ctx_changed) begin
          counter_next = '0;
        end else if (counting) begin
          counter_next = counter_reg + QUANTUM_W'(1);
        end
      end
      default: begin
        if (fetch_ack) begin
          if (stub_last) begin
            state_next        = ST_RUN;
            idx_next          = '0;
            counter_next      = '0;
            switch_count_next = switch_count_reg + 16'd1;
          end else begin
            idx_next = idx_reg + SIDX_W'(1);
          end
        end
      end
    endcase
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_RUN;
      counter_reg      <= '0;
      idx_reg          <= '0;
      ctx_prev_reg     <= '0;
      saved_pc_reg     <= '0;
      switch_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      counter_reg      <= counter_next;
      idx_reg          <= idx_next;
      ctx_prev_reg     <= contexto;
      saved_pc_reg     <= saved_pc_next;
      switch_count_reg <= switch_count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        quantum_reg[i] <= QUANTUM_W'(DEFAULT_QUANTUM);
      end
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (quantum_hit[i]) begin
          quantum_reg[i] <= cfg_data[QUANTUM_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg <= LEN_W'(1);
      for (int i = 0; i < STUB_DEPTH; i++) begin
        stub_reg[i] <= NOP_INSTR;
      end
    end else begin
      if (len_we) begin
        len_reg <= len_clamped;
      end
      for (int i = 0; i < STUB_DEPTH; i++) begin
        if (stub_hit[i]) begin
          stub_reg[i] <= cfg_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign flag_pausa      = (state_reg == ST_PAUSE);
  assign saida_instrucao = (state_reg == ST_PAUSE) ? stub_reg[idx_reg] : NOP_INSTR;
  assign quantum_left    = (state_reg == ST_PAUSE) ? '0 : (q_cur - counter_reg);
  assign saved_pc        = saved_pc_reg;
  assign switch_count    = switch_count_reg;

endmodule

// File: tb/tb_temporizador_preemptivo.sv
// Bench for temporizador_preemptivo: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_temporizador_preemptivo;

  localparam int NUM_CTX = 4;
  localparam int SD      = 8;
  localparam logic [31:0] NOP  = 32'hA000_0000;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h2222_0002, WC = 32'h3333_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] contexto = '0;
  logic [31:0] end_pc = '0;
  logic        enable = 1'b0;
  logic        force_switch = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [31:0] saida_instrucao;
  logic        flag_pausa;
  logic [31:0] saved_pc;
  logic [15:0] quantum_left;
  logic [15:0] switch_count;

  temporizador_preemptivo dut (
    .clk(clk), .rst(rst), .contexto(contexto), .end_pc(end_pc), .enable(enable),
    .force_switch(force_switch), .fetch_ack(fetch_ack), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .saida_instrucao(saida_instrucao), .flag_pausa(flag_pausa), .saved_pc(saved_pc),
    .quantum_left(quantum_left), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  int unsigned m_q [NUM_CTX];
  logic [31:0] m_stub [SD];
  int          m_len;
  bit          m_paused;
  int unsigned m_cnt;
  logic [31:0] m_prev;
  logic [31:0] m_saved;
  int unsigned m_sw;
  logic [31:0] m_pend [$];

  task automatic model_reset();
    for (int i = 0; i < NUM_CTX; i++) m_q[i] = 300;
    for (int i = 0; i < SD; i++) m_stub[i] = NOP;
    m_len = 1; m_paused = 0; m_cnt = 0; m_prev = '0; m_saved = '0; m_sw = 0;
    m_pend.delete();
  endtask

  task automatic model_step();
    bit was_paused;
    bit changed, counting, expire;
    int unsigned q;
    was_paused = m_paused;
    if (cfg_we && !was_paused) begin
      if (cfg_sel == 2'd1) m_stub[cfg_addr % SD] = cfg_data;
      if (cfg_sel == 2'd2) m_len = (cfg_data == 0) ? 1 : ((cfg_data > SD) ? SD : int'(cfg_data));
    end
    if (was_paused) begin
      if (fetch_ack) begin
        void'(m_pend.pop_front());
        if (m_pend.size() == 0) begin
          m_paused = 0; m_cnt = 0; m_sw = (m_sw + 1) % 65536;
        end
      end
    end else begin
      q = m_q[contexto % NUM_CTX];
      changed  = (contexto != m_prev);
      counting = enable && (contexto != 0);
      expire   = counting && !changed && (q != 0) && (m_cnt + 1 >= q);
      if (expire || (force_switch && contexto != 0)) begin
        m_paused = 1;
        m_pend.delete();
        for (int i = 0; i < m_len; i++) m_pend.push_back(m_stub[i]);
        m_cnt = 0;
        m_saved = end_pc;
      end else if (changed) begin
        m_cnt = 0;
      end else if (counting) begin
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
    m_prev = contexto;
    if (cfg_we && cfg_sel == 2'd0) m_q[cfg_addr % NUM_CTX] = int'(cfg_data[15:0]);
  endtask

  always @(posedge clk) begin
    logic [31:0] exp_out, exp_ql;
    if (!rst) model_step();
    #1;
    exp_out = m_paused ? m_pend[0] : NOP;
    exp_ql  = m_paused ? 32'd0 : ((m_q[contexto % NUM_CTX] - m_cnt) & 32'hFFFF);
    check("flag_pausa", {31'b0, flag_pausa}, {31'b0, m_paused});
    check("saida_instrucao", saida_instrucao, exp_out);
    check("saved_pc", saved_pc, m_saved);
    check("quantum_left", {16'b0, quantum_left}, exp_ql);
    check("switch_count", {16'b0, switch_count}, m_sw & 32'hFFFF);
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_flag(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (flag_pausa) begin n = i; break; end
    end
  endtask

  task automatic ack_once();
    fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
  endtask

  task automatic pulse_force();
    force_switch = 1'b1; tick(); force_switch = 1'b0;
  endtask

  // ------------------------------------------------------------ main sequence
  initial begin
    int n;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    check("reset_flag", {31'b0, flag_pausa}, 32'd0);
    check("reset_saida", saida_instrucao, NOP);
    check("reset_quantum_left", {16'b0, quantum_left}, 32'd300);
    check("reset_switch_count", {16'b0, switch_count}, 32'd0);
    $display("reset released");

    // quantum[1]=5: expiry on the 5th counting edge after the context change
    contexto = 1; enable = 1'b1; end_pc = BASE;
    cfg(2'd0, 8'd1, 32'd5);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      end_pc = BASE + i;
      tick();
      if (flag_pausa) begin n = i; break; end
    end
    check("expiry_edges_q5", n, 32'd5);
    check("saved_pc_q5", saved_pc, BASE + 5);
    check("stub0_nop", saida_instrucao, NOP);
    ack_once();
    check("release_q5_flag", {31'b0, flag_pausa}, 32'd0);
    check("release_q5_count", {16'b0, switch_count}, 32'd1);
    enable = 1'b0;
    $display("quantum=5 expiry: %0d edges", n);

    // three-word stub with a stall and dropped writes during the pause
    cfg(2'd1, 8'd0, WA); cfg(2'd1, 8'd1, WB); cfg(2'd1, 8'd2, WC); cfg(2'd2, 8'd0, 32'd3);
    pulse_force();
    check("forced_flag", {31'b0, flag_pausa}, 32'd1);
    check("stub_word_A", saida_instrucao, WA);
    ack_once();
    check("stub_word_B", saida_instrucao, WB);
    cfg(2'd1, 8'd1, 32'hDEAD_BEEF);
    check("stub_stall_B", saida_instrucao, WB);
    force_switch = 1'b1; cfg(2'd2, 8'd0, 32'd0); force_switch = 1'b0;
    check("stub_stall2_B", saida_instrucao, WB);
    ack_once();
    check("stub_word_C", saida_instrucao, WC);
    check("stub_flag_before_last", {31'b0, flag_pausa}, 32'd1);
    ack_once();
    check("stub_done_flag", {31'b0, flag_pausa}, 32'd0);
    check("stub_done_count", {16'b0, switch_count}, 32'd2);
    cfg(2'd2, 8'd0, 32'd0);
    pulse_force();
    check("len0_word", saida_instrucao, WA);
    ack_once();
    check("len0_single_word", {31'b0, flag_pausa}, 32'd0);
    check("len0_count", {16'b0, switch_count}, 32'd3);
    $display("stub emission done, switch_count=%0d", switch_count);

    // SO context never preempted; context 2 with default quantum
    contexto = 0; enable = 1'b1;
    cfg(2'd0, 8'd0, 32'd5);
    repeat (1000) tick();
    check("so_no_pause", {31'b0, flag_pausa}, 32'd0);
    contexto = 2;
    wait_flag(400, n);
    check("expiry_edges_q300", n, 32'd301);
    ack_once();
    $display("ctx2 default quantum: flag after %0d edges", n);

    // quantum 0 never expires; force works; force during pause ignored
    cfg(2'd0, 8'd3, 32'd0);
    contexto = 3;
    repeat (70000) tick();
    check("q0_no_pause", {31'b0, flag_pausa}, 32'd0);
    pulse_force();
    check("q0_forced_flag", {31'b0, flag_pausa}, 32'd1);
    pulse_force();
    check("force_in_pause_flag", {31'b0, flag_pausa}, 32'd1);
    check("force_in_pause_count", {16'b0, switch_count}, 32'd4);
    ack_once();
    check("q0_release_count", {16'b0, switch_count}, 32'd5);
    $display("quantum 0 context: forced switch only");

    // context change reloads the counter; expiry plus force gives one switch
    cfg(2'd0, 8'd1, 32'd10); cfg(2'd0, 8'd2, 32'd10);
    contexto = 1; tick();
    repeat (4) tick();
    check("ctx1_left_at_4", {16'b0, quantum_left}, 32'd6);
    contexto = 2; tick();
    check("ctx2_reload_left", {16'b0, quantum_left}, 32'd10);
    repeat (9) tick();
    check("ctx2_before_expiry", {31'b0, flag_pausa}, 32'd0);
    pulse_force();
    check("ctx2_expiry_flag", {31'b0, flag_pausa}, 32'd1);
    ack_once();
    check("single_switch_count", {16'b0, switch_count}, 32'd6);
    $display("context reload and coincident force checked");

    // asynchronous reset in the middle of a stub
    enable = 1'b0;
    cfg(2'd2, 8'd0, 32'd3);
    pulse_force();
    ack_once();
    check("mid_stub_word", saida_instrucao, WB);
    #2 rst = 1'b1;
    #1;
    check("async_rst_flag", {31'b0, flag_pausa}, 32'd0);
    check("async_rst_saida", saida_instrucao, NOP);
    check("async_rst_quantum", {16'b0, quantum_left}, 32'd300);
    check("async_rst_count", {16'b0, switch_count}, 32'd0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    $display("async reset mid-stub checked");

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) contexto = $urandom_range(0, 5);
      enable       = ($urandom_range(0, 9) != 0);
      force_switch = ($urandom_range(0, 60) == 0);
      fetch_ack    = $urandom_range(0, 1);
      cfg_we       = ($urandom_range(0, 15) == 0);
      cfg_sel      = 2'($urandom_range(0, 3));
      cfg_addr     = 8'($urandom_range(0, 255));
      case (cfg_sel)
        2'd0:    cfg_data = $urandom_range(0, 30);
        2'd2:    cfg_data = $urandom_range(0, 12);
        default: cfg_data = $urandom();
      endcase
      end_pc = $urandom();
      tick();
    end
    cfg_we = 1'b0; force_switch = 1'b0; fetch_ack = 1'b0;
    tick();
    $display("random phase done, switch_count=%0d", switch_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
